// File: rtl/out_node_sampler.sv
// Readout stage for the analog "out" node: paces ADC conversions with a divider,
// averages 2^AVG_LOG2 codes and offers the truncated mean on a valid/ready port.
module out_node_sampler #(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2,
  parameter int DIV_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  div,
  output logic              conv_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] avg_data,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic              overrun,
  output logic              busy
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(2 ** AVG_LOG2);

  typedef enum logic [1:0] {IDLE, WAIT, CONV, OUT} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               conv_start_q, conv_start_d;
  logic [DATA_W-1:0]  avg_data_q, avg_data_d;
  logic               avg_valid_q, avg_valid_d;
  logic               overrun_q, overrun_d;
  logic               busy_q, busy_d;

  logic               tick;
  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   cnt_inc;

  always_comb begin
    tick    = en && (state_q != IDLE) && (tick_cnt_q == '0);
    acc_sum = acc_q + ACC_W'(adc_data);
    cnt_inc = cnt_q + CNT_W'(1);

    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    conv_start_d = 1'b0;
    avg_data_d   = avg_data_q;
    avg_valid_d  = avg_valid_q;
    overrun_d    = overrun_q;

    if (en && (state_q != IDLE)) begin
      tick_cnt_d = tick ? div : tick_cnt_q - DIV_W'(1);
    end

    // A tick that finds us still converting or holding a result is simply lost.
    if (tick && ((state_q == CONV) || (state_q == OUT))) begin
      overrun_d = 1'b1;
    end

    if (!en) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      avg_valid_d = 1'b0;
      if (state_q == IDLE) begin
        overrun_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = WAIT;
          tick_cnt_d = div;
        end
        WAIT: begin
          if (tick) begin
            state_d      = CONV;
            conv_start_d = 1'b1;
          end
        end
        CONV: begin
          if (adc_done) begin
            acc_d = acc_sum;
            cnt_d = cnt_inc;
            if (cnt_inc == N_SAMPLES) begin
              avg_data_d  = acc_sum[ACC_W-1:AVG_LOG2];
              avg_valid_d = 1'b1;
              state_d     = OUT;
            end else begin
              state_d = WAIT;
            end
          end
        end
        OUT: begin
          if (avg_ready) begin
            state_d     = WAIT;
            acc_d       = '0;
            cnt_d       = '0;
            avg_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      conv_start_q <= 1'b0;
      avg_data_q   <= '0;
      avg_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      conv_start_q <= conv_start_d;
      avg_data_q   <= avg_data_d;
      avg_valid_q  <= avg_valid_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign conv_start = conv_start_q;
  assign avg_data   = avg_data_q;
  assign avg_valid  = avg_valid_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_out_node_sampler.sv
// Directed bench for out_node_sampler: pacing, averaging, backpressure,
// slow ADC, enable abort and asynchronous reset.
module tb_out_node_sampler;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] div;
  logic        conv_start;
  logic        adc_done;
  logic [11:0] adc_data;
  logic [11:0] avg_data;
  logic        avg_valid;
  logic        avg_ready;
  logic        overrun;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;
  int gap;

  out_node_sampler #(.DATA_W(12), .AVG_LOG2(2), .DIV_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div        (div),
    .conv_start (conv_start),
    .adc_done   (adc_done),
    .adc_data   (adc_data),
    .avg_data   (avg_data),
    .avg_valid  (avg_valid),
    .avg_ready  (avg_ready),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en_i, input logic [15:0] div_i, input logic ready_i);
    en        = en_i;
    div       = div_i;
    avg_ready = ready_i;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  // Steps until conv_start is seen (bounded); n is the number of edges taken.
  task automatic waitConv(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!conv_start && n < 100);
  endtask

  // Called in a conv_start cycle: waits lat cycles, then strobes adc_done with data.
  task automatic convert(input logic [11:0] data, input int lat);
    for (int i = 0; i < lat; i++) begin
      step();
      checkOutput("cs_single", conv_start, 0);
    end
    adc_done = 1'b1;
    adc_data = data;
    step();
    adc_done = 1'b0;
    adc_data = '0;
  endtask

  initial begin
    rst      = 1'b1;
    adc_done = 1'b0;
    adc_data = '0;
    applyStimulus(1'b0, 16'd3, 1'b1);
    step();
    step();
    checkOutput("rst_conv_start", conv_start, 0);
    checkOutput("rst_avg_data", avg_data, 0);
    checkOutput("rst_avg_valid", avg_valid, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // Basic averaging, div=3
    applyStimulus(1'b1, 16'd3, 1'b1);
    waitConv(gap);
    checkOutput("t1_first_gap", gap, 5);
    checkOutput("t1_busy", busy, 1);
    convert(12'd100, 0);
    waitConv(gap);
    checkOutput("t1_gap2", gap, 3);
    convert(12'd101, 0);
    waitConv(gap);
    checkOutput("t1_gap3", gap, 3);
    convert(12'd102, 0);
    waitConv(gap);
    checkOutput("t1_gap4", gap, 3);
    convert(12'd103, 0);
    checkOutput("t1_valid", avg_valid, 1);
    checkOutput("t1_avg", avg_data, 101);
    step();
    checkOutput("t1_valid_drop", avg_valid, 0);
    checkOutput("t1_avg_held", avg_data, 101);
    checkOutput("t1_overrun", overrun, 0);

    // Truncation at full scale
    waitConv(gap);
    checkOutput("t2_gap1", gap, 2);
    convert(12'd4095, 0);
    waitConv(gap);
    checkOutput("t2_gap2", gap, 3);
    convert(12'd4095, 0);
    waitConv(gap);
    checkOutput("t2_gap3", gap, 3);
    convert(12'd4095, 0);
    waitConv(gap);
    checkOutput("t2_gap4", gap, 3);
    convert(12'd4094, 0);
    checkOutput("t2_valid", avg_valid, 1);
    checkOutput("t2_avg", avg_data, 4094);
    step();
    checkOutput("t2_valid_drop", avg_valid, 0);
    checkOutput("t2_overrun", overrun, 0);

    // Backpressure with div=1
    applyStimulus(1'b1, 16'd1, 1'b0);
    waitConv(gap);
    checkOutput("t3_gap1", gap, 2);
    convert(12'd10, 0);
    waitConv(gap);
    checkOutput("t3_gap2", gap, 1);
    convert(12'd20, 0);
    waitConv(gap);
    checkOutput("t3_gap3", gap, 1);
    convert(12'd30, 0);
    waitConv(gap);
    checkOutput("t3_gap4", gap, 1);
    convert(12'd40, 0);
    checkOutput("t3_valid", avg_valid, 1);
    checkOutput("t3_avg", avg_data, 25);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("t3_hold_valid", avg_valid, 1);
      checkOutput("t3_hold_avg", avg_data, 25);
      checkOutput("t3_no_conv", conv_start, 0);
    end
    checkOutput("t3_overrun", overrun, 1);
    applyStimulus(1'b1, 16'd1, 1'b1);
    step();
    checkOutput("t3_valid_drop", avg_valid, 0);
    checkOutput("t3_overrun_sticky", overrun, 1);
    applyStimulus(1'b0, 16'd1, 1'b1);
    step();
    checkOutput("t3_idle_busy", busy, 0);
    step();
    checkOutput("t3_overrun_clear", overrun, 0);

    // Slow ADC with div=0
    applyStimulus(1'b1, 16'd0, 1'b1);
    waitConv(gap);
    checkOutput("t4_first_gap", gap, 2);
    convert(12'd50, 5);
    checkOutput("t4_overrun", overrun, 1);
    waitConv(gap);
    checkOutput("t4_gap2", gap, 1);
    convert(12'd60, 0);
    waitConv(gap);
    checkOutput("t4_gap3", gap, 1);

    // Abort in CONV after two samples, late done ignored
    applyStimulus(1'b0, 16'd0, 1'b0);
    step();
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_conv_start", conv_start, 0);
    checkOutput("t5_valid", avg_valid, 0);
    adc_done = 1'b1;
    adc_data = 12'd4000;
    step();
    adc_done = 1'b0;
    adc_data = '0;
    checkOutput("t5_overrun_clear", overrun, 0);
    applyStimulus(1'b1, 16'd0, 1'b0);
    waitConv(gap);
    checkOutput("t5_first_gap", gap, 2);
    convert(12'd1, 0);
    checkOutput("t5_valid_early1", avg_valid, 0);
    waitConv(gap);
    convert(12'd2, 0);
    checkOutput("t5_valid_early2", avg_valid, 0);
    waitConv(gap);
    convert(12'd3, 0);
    checkOutput("t5_valid_early3", avg_valid, 0);
    waitConv(gap);
    checkOutput("t5_gap4", gap, 1);
    convert(12'd6, 0);
    checkOutput("t5_valid", avg_valid, 1);
    checkOutput("t5_avg", avg_data, 3);
    step();
    checkOutput("t5_hold_valid", avg_valid, 1);

    // Asynchronous reset while holding a result
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_conv_start", conv_start, 0);
    checkOutput("t6_avg_data", avg_data, 0);
    checkOutput("t6_avg_valid", avg_valid, 0);
    checkOutput("t6_overrun", overrun, 0);
    checkOutput("t6_busy", busy, 0);
    step();
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
